// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core support logic: halt encoding,
// pipeline depth and the program loader state encoding.
package risc_pkg;

  localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;
  localparam int unsigned PIPE_STAGES = 4;

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_PAD,
    S_RUN,
    S_ERR
  } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses
// combinationally in the cycle the fourth byte of a word is accepted.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  byte_cnt
);

  logic [23:0] low;

  // The top byte is taken straight from the bus so the word is complete
  // in the same cycle as its last byte.
  assign word       = {data, low};
  assign word_valid = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      low      <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    low[7:0]   <= data;
        2'd1:    low[15:8]  <= data;
        2'd2:    low[23:16] <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, appends the
// halt padding, then runs the core until it halts.
module imem_program_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PAD_WORDS = risc_pkg::PIPE_STAGES,
  parameter logic [31:0] HALT_WORD = risc_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import risc_pkg::*;

  localparam logic [31:0]     MAX_LEN  = 32'((2 ** ADDR_W) - PAD_WORDS);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] LAST_PAD = (ADDR_W + 1)'(PAD_WORDS - 1);

  loader_state_e   state, state_next;
  logic [ADDR_W:0] word_cnt, len, pad_cnt;
  logic            accept, pack_clear, word_valid;
  logic [31:0]     word;
  logic [1:0]      byte_cnt;

  assign accept     = rx_valid && rx_ready;
  assign pack_clear = !((state == S_HDR) || (state == S_LOAD));

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .data       (rx_data),
    .accept     (accept),
    .word       (word),
    .word_valid (word_valid),
    .byte_cnt   (byte_cnt)
  );

  // Length check uses all 32 header bits so large headers cannot alias.
  always_comb begin
    state_next = state;
    case (state)
      S_HDR: begin
        if (word_valid) begin
          if (word == '0)          state_next = S_PAD;
          else if (word > MAX_LEN) state_next = S_ERR;
          else                     state_next = S_LOAD;
        end
      end
      S_LOAD:  if (word_valid && (word_cnt == len - ONE)) state_next = S_PAD;
      S_PAD:   if (pad_cnt == LAST_PAD) state_next = S_RUN;
      S_RUN:   if (cpu_halt) state_next = S_HDR;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  // Writes land one cycle after the deciding state cycle, so the core is
  // released from S_RUN's own registered view to keep it clear of the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HDR;
      word_cnt   <= '0;
      len        <= '0;
      pad_cnt    <= '0;
      rx_ready   <= 1'b0;
      imem_wen   <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
    end else begin
      state     <= state_next;
      rx_ready  <= (state_next == S_HDR) || (state_next == S_LOAD);
      cpu_rst_n <= (state == S_RUN) && !cpu_halt;
      imem_wen  <= 1'b0;
      case (state)
        S_HDR: begin
          if (word_valid) begin
            len      <= word[ADDR_W:0];
            word_cnt <= '0;
            pad_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            imem_wen   <= 1'b1;
            imem_waddr <= word_cnt[ADDR_W-1:0];
            imem_wdata <= word;
            word_cnt   <= word_cnt + ONE;
          end
        end
        S_PAD: begin
          imem_wen   <= 1'b1;
          imem_waddr <= word_cnt[ADDR_W-1:0];
          imem_wdata <= HALT_WORD;
          word_cnt   <= word_cnt + ONE;
          pad_cnt    <= pad_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == S_LOAD) || (state == S_PAD) ||
                 ((state == S_HDR) && (byte_cnt != 2'd0));
  assign done  = (state == S_RUN);
  assign error = (state == S_ERR);

endmodule
